dpram_rr_arbiter: RTL and testbench

DPRAM_RR_ARBITER -- requirements
Module: dpram_rr_arbiter

---
 rtl/dpram_pkg.sv | 18 +
 rtl/dpram_array.sv | 47 ++++
 rtl/dpram_rr_arbiter.sv | 103 ++++++++++
 tb/tb_dpram_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared defaults and encodings for the arbitrated dual-port RAM.
package dpram_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int DEF_CNT_W  = 8;

  // Value carried on a_we / b_we
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/dpram_array.sv
// DEPTH x DATA_W storage with two write ports and two registered read ports.
// Reads return the contents from before any write on the same edge.
module dpram_array
  import dpram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Write enables arrive already arbitrated, so the two ports never collide.
  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_addr] <= a_wdata;
    if (b_we) mem_q[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re) a_rdata_q <= mem_q[a_addr];
      if (b_re) b_rdata_q <= mem_q[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Dual-port RAM front end: same-address conflicts involving a write are
// serialised by a round-robin favour bit; conflicts are counted (saturating).
module dpram_rr_arbiter
  import dpram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              rr_favor
);

  port_e             rr_favor_q, rr_favor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic              conflict;
  logic              a_wr, a_rd, b_wr, b_rd;
  logic [DATA_W-1:0] a_rdata_mem, b_rdata_mem;

  assign conflict = a_req & b_req & (a_addr == b_addr)
                  & ((a_we == OP_WR) | (b_we == OP_WR));

  assign a_gnt = ~reset & a_req & (~conflict | (rr_favor_q == PORT_A));
  assign b_gnt = ~reset & b_req & (~conflict | (rr_favor_q == PORT_B));

  assign a_wr = a_gnt & (a_we == OP_WR);
  assign a_rd = a_gnt & (a_we == OP_RD);
  assign b_wr = b_gnt & (b_we == OP_WR);
  assign b_rd = b_gnt & (b_we == OP_RD);

  always_comb begin
    rr_favor_d = rr_favor_q;
    cnt_d      = cnt_q;
    a_rvalid_d = a_rd;
    b_rvalid_d = b_rd;
    if (conflict) begin
      rr_favor_d = (rr_favor_q == PORT_A) ? PORT_B : PORT_A;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_favor_q <= PORT_A;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      rr_favor_q <= rr_favor_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  dpram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .a_we    (a_wr),
    .a_re    (a_rd),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata_mem),
    .b_we    (b_wr),
    .b_re    (b_rd),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata_mem)
  );

  // Outputs are forced low for the whole reset cycle, which also swallows a
  // read response that would otherwise appear in the first reset cycle.
  assign a_rvalid     = a_rvalid_q & ~reset;
  assign b_rvalid     = b_rvalid_q & ~reset;
  assign a_rdata      = reset ? '0 : a_rdata_mem;
  assign b_rdata      = reset ? '0 : b_rdata_mem;
  assign conflict_cnt = reset ? '0 : cnt_q;
  assign rr_favor     = ~reset & (rr_favor_q == PORT_B);

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Directed, table-driven bench for dpram_rr_arbiter (built with CNT_W=2).
module tb_dpram_rr_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 2;
  localparam int NVEC   = 21;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, rr_favor;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [CNT_W-1:0]  conflict_cnt;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  typedef struct {
    logic        rst;
    logic        a_req;
    logic        a_we;
    logic [3:0]  a_addr;
    logic [7:0]  a_wd;
    logic        b_req;
    logic        b_we;
    logic [3:0]  b_addr;
    logic [7:0]  b_wd;
    logic        ea_gnt;
    logic        eb_gnt;
    logic        ea_rv;
    logic [7:0]  ea_rd;
    logic        eb_rv;
    logic [7:0]  eb_rd;
    logic [1:0]  ecnt;
    logic        efav;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  dpram_rr_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a_req        (a_req),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_wdata      (a_wdata),
    .a_gnt        (a_gnt),
    .a_rvalid     (a_rvalid),
    .a_rdata      (a_rdata),
    .b_req        (b_req),
    .b_we         (b_we),
    .b_addr       (b_addr),
    .b_wdata      (b_wdata),
    .b_gnt        (b_gnt),
    .b_rvalid     (b_rvalid),
    .b_rdata      (b_rdata),
    .conflict_cnt (conflict_cnt),
    .rr_favor     (rr_favor)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [3:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  initial begin
    // rst, A{req,we,addr,wd}, B{req,we,addr,wd}, gntA, gntB, rvA, rdA, rvB, rdB, cnt, fav
    vecs[0]  = '{1'b0, 1'b1,1'b1,4'd2,8'h3C, 1'b1,1'b1,4'd9,8'hA5, 1'b1,1'b1, 1'b0,8'h00, 1'b0,8'h00, 2'd0,1'b0};
    vecs[1]  = '{1'b0, 1'b1,1'b0,4'd2,8'h00, 1'b1,1'b0,4'd9,8'h00, 1'b1,1'b1, 1'b1,8'h3C, 1'b1,8'hA5, 2'd0,1'b0};
    vecs[2]  = '{1'b0, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0, 1'b0,8'h3C, 1'b0,8'hA5, 2'd0,1'b0};
    vecs[3]  = '{1'b0, 1'b1,1'b1,4'd7,8'h5A, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'h3C, 1'b0,8'hA5, 2'd0,1'b0};
    vecs[4]  = '{1'b0, 1'b1,1'b0,4'd7,8'h00, 1'b1,1'b0,4'd7,8'h00, 1'b1,1'b1, 1'b1,8'h5A, 1'b1,8'h5A, 2'd0,1'b0};
    vecs[5]  = '{1'b0, 1'b1,1'b1,4'd5,8'h11, 1'b1,1'b1,4'd5,8'h22, 1'b1,1'b0, 1'b0,8'h5A, 1'b0,8'h5A, 2'd1,1'b1};
    vecs[6]  = '{1'b0, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,4'd5,8'h22, 1'b0,1'b1, 1'b0,8'h5A, 1'b0,8'h5A, 2'd1,1'b1};
    vecs[7]  = '{1'b0, 1'b1,1'b0,4'd5,8'h00, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b1,8'h22, 1'b0,8'h5A, 2'd1,1'b1};
    vecs[8]  = '{1'b0, 1'b1,1'b0,4'd9,8'h00, 1'b1,1'b1,4'd2,8'h44, 1'b1,1'b1, 1'b1,8'hA5, 1'b0,8'h5A, 2'd1,1'b1};
    vecs[9]  = '{1'b0, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0,4'd2,8'h00, 1'b0,1'b1, 1'b0,8'hA5, 1'b1,8'h44, 2'd1,1'b1};
    vecs[10] = '{1'b0, 1'b1,1'b1,4'd3,8'h10, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b0, 1'b0,8'hA5, 1'b0,8'h44, 2'd1,1'b1};
    vecs[11] = '{1'b0, 1'b1,1'b0,4'd3,8'h00, 1'b1,1'b1,4'd3,8'h77, 1'b0,1'b1, 1'b0,8'hA5, 1'b0,8'h44, 2'd2,1'b0};
    vecs[12] = '{1'b0, 1'b1,1'b0,4'd3,8'h00, 1'b1,1'b1,4'd3,8'h77, 1'b1,1'b0, 1'b1,8'h77, 1'b0,8'h44, 2'd3,1'b1};
    vecs[13] = '{1'b0, 1'b0,1'b0,4'd0,8'h00, 1'b1,1'b1,4'd3,8'h77, 1'b0,1'b1, 1'b0,8'h77, 1'b0,8'h44, 2'd3,1'b1};
    vecs[14] = '{1'b1, 1'b1,1'b1,4'd3,8'hEE, 1'b1,1'b0,4'd3,8'h00, 1'b0,1'b0, 1'b0,8'h00, 1'b0,8'h00, 2'd0,1'b0};
    vecs[15] = '{1'b0, 1'b1,1'b1,4'd4,8'h01, 1'b1,1'b1,4'd4,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 2'd1,1'b1};
    vecs[16] = '{1'b0, 1'b1,1'b1,4'd4,8'h01, 1'b1,1'b1,4'd4,8'h02, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 2'd2,1'b0};
    vecs[17] = '{1'b0, 1'b1,1'b1,4'd4,8'h01, 1'b1,1'b1,4'd4,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 2'd3,1'b1};
    vecs[18] = '{1'b0, 1'b1,1'b1,4'd4,8'h01, 1'b1,1'b1,4'd4,8'h02, 1'b0,1'b1, 1'b0,8'h00, 1'b0,8'h00, 2'd3,1'b0};
    vecs[19] = '{1'b0, 1'b1,1'b1,4'd4,8'h01, 1'b1,1'b1,4'd4,8'h02, 1'b1,1'b0, 1'b0,8'h00, 1'b0,8'h00, 2'd3,1'b1};
    vecs[20] = '{1'b0, 1'b1,1'b0,4'd4,8'h00, 1'b1,1'b0,4'd3,8'h00, 1'b1,1'b1, 1'b1,8'h01, 1'b1,8'h77, 2'd3,1'b1};

    // Reset with requests pending: grants stay low, registered outputs clear.
    reset = 1'b1;
    drive(1'b1, 1'b1, 4'd0, 8'hFF, 1'b1, 1'b0, 4'd0, 8'h00);
    @(negedge clk); #1;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", {24'd0, b_rdata}, 32'd0);
    chk("rst_cnt", {30'd0, conflict_cnt}, 32'd0);
    chk("rst_favor", {31'd0, rr_favor}, 32'd0);
    $display("reset: gnt=%b%b rvalid=%b%b cnt=%0d favor=%b", a_gnt, b_gnt, a_rvalid, b_rvalid, conflict_cnt, rr_favor);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      reset = vecs[i].rst;
      drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd,
            vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd);
      #1;
      chk($sformatf("v%0d_a_gnt", i), {31'd0, a_gnt}, {31'd0, vecs[i].ea_gnt});
      chk($sformatf("v%0d_b_gnt", i), {31'd0, b_gnt}, {31'd0, vecs[i].eb_gnt});
      @(posedge clk); #1;
      chk($sformatf("v%0d_a_rvalid", i), {31'd0, a_rvalid}, {31'd0, vecs[i].ea_rv});
      chk($sformatf("v%0d_a_rdata", i), {24'd0, a_rdata}, {24'd0, vecs[i].ea_rd});
      chk($sformatf("v%0d_b_rvalid", i), {31'd0, b_rvalid}, {31'd0, vecs[i].eb_rv});
      chk($sformatf("v%0d_b_rdata", i), {24'd0, b_rdata}, {24'd0, vecs[i].eb_rd});
      chk($sformatf("v%0d_cnt", i), {30'd0, conflict_cnt}, {30'd0, vecs[i].ecnt});
      chk($sformatf("v%0d_favor", i), {31'd0, rr_favor}, {31'd0, vecs[i].efav});
      $display("vec %0d: rst=%b a(req=%b we=%b @%0d) b(req=%b we=%b @%0d) gnt=%b%b rv=%b%b rd=%02h/%02h cnt=%0d fav=%b",
               i, vecs[i].rst, vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr,
               vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr,
               vecs[i].ea_gnt, vecs[i].eb_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
               conflict_cnt, rr_favor);
    end

    // Read granted, then reset in the response cycle: the response must vanish.
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    chk("prerst_a_gnt", {31'd0, a_gnt}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    chk("inrst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("inrst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("inrst_cnt", {30'd0, conflict_cnt}, 32'd0);
    chk("inrst_favor", {31'd0, rr_favor}, 32'd0);
    @(posedge clk); #1;
    chk("rst2_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("postrst_a_rdata", {24'd0, a_rdata}, 32'd0);
    chk("postrst_cnt", {30'd0, conflict_cnt}, 32'd0);
    $display("read-then-reset: rvalid=%b rdata=%02h cnt=%0d favor=%b", a_rvalid, a_rdata, conflict_cnt, rr_favor);

    // First conflict after reset goes to port A.
    @(negedge clk);
    drive(1'b1, 1'b1, 4'd6, 8'h33, 1'b1, 1'b0, 4'd6, 8'h00);
    #1;
    chk("first_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("first_b_gnt", {31'd0, b_gnt}, 32'd0);
    @(posedge clk); #1;
    chk("first_favor", {31'd0, rr_favor}, 32'd1);
    chk("first_cnt", {30'd0, conflict_cnt}, 32'd1);
    $display("first conflict: gnt=10 favor=%b cnt=%0d", rr_favor, conflict_cnt);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
